// File: rtl/aes_pkg.sv
// Shared AES-128 constants and types for the key schedule and round datapath.
package aes_pkg;

    localparam int NR      = 10;              // number of rounds for AES-128
    localparam int RK_W    = 128;             // width of one round key
    localparam int SCHED_W = RK_W * (NR + 1); // rk0..rk10 packed back to back
    localparam int CNT_W   = 4;               // round counter width, holds 0..NR

    // Round constants Rcon[1..10]; index 1 is the leftmost byte.
    localparam logic [1:NR][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: one byte in, one substituted byte out.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Table index 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[a];

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: loads rk0 on start, then produces one
// round key per clock until rk10 is written and finish is raised.
module aes_key_expansion
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [RK_W-1:0]    key,
    input  logic               start,
    output logic [SCHED_W-1:0] out,
    output logic               finish
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;        // index of the round key written next
    logic [RK_W-1:0]  key_q;      // key the current schedule belongs to
    logic [RK_W-1:0]  prev_rk;    // most recently written round key
    logic [RK_W-1:0]  next_rk;
    logic             key_new;
    logic             load;
    logic             step;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w, sub_w, t_w;
    logic [31:0] n0, n1, n2, n3;
    logic [7:0]  rcon_b;

    assign key_new = (key != key_q);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: a new key in DONE restarts exactly like IDLE.
    always_comb begin
        // NOTE: a default first keeps every path assigned, so no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (start)                 state_nxt = BUSY;
            BUSY:    if (cnt == CNT_W'(NR))     state_nxt = DONE;
            DONE:    if (start && key_new)      state_nxt = BUSY;
            default:                            state_nxt = IDLE;
        endcase
    end

    // Output/control decode from the current state.
    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        case (state)
            IDLE:    load = start;
            BUSY:    step = 1'b1;
            DONE: begin
                finish = 1'b1;
                load   = start && key_new;
            end
            default: ;
        endcase
    end

    // Round function datapath: rotate, substitute, add Rcon, XOR chain.
    always_comb begin
        {w0, w1, w2, w3} = prev_rk;
        rcon_b = 8'h00;
        if (cnt >= CNT_W'(1) && cnt <= CNT_W'(NR)) rcon_b = RCON[cnt];
        rot_w   = {w3[23:0], w3[31:24]};
        t_w     = sub_w ^ {rcon_b, 24'h000000};
        n0      = w0 ^ t_w;
        n1      = w1 ^ n0;
        n2      = w2 ^ n1;
        n3      = w3 ^ n2;
        next_rk = {n0, n1, n2, n3};
    end

    genvar g;
    for (g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot_w[8*g +: 8]),
            .y (sub_w[8*g +: 8])
        );
    end

    // Schedule storage: load rk0 and clear the rest, or write one slot per step.
    always_ff @(posedge clk) begin
        // NOTE: the schedule register is reset because out is visible to
        // consumers and must read as zero after reset.
        if (rst) begin
            out     <= '0;
            cnt     <= '0;
            key_q   <= '0;
            prev_rk <= '0;
        end else if (load) begin
            out     <= {key, {(SCHED_W-RK_W){1'b0}}};
            key_q   <= key;
            prev_rk <= key;
            cnt     <= CNT_W'(1);
        end else if (step) begin
            for (int i = 1; i <= NR; i++) begin
                if (cnt == CNT_W'(i)) out[SCHED_W-1-RK_W*i -: RK_W] <= next_rk;
            end
            prev_rk <= next_rk;
            cnt     <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion against a GF(2^8)-based
// reference key schedule.
module tb_aes_key_expansion;
    import aes_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [RK_W-1:0]    key;
    logic               start;
    logic [SCHED_W-1:0] out;
    logic               finish;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb_model [256];

    aes_key_expansion dut (
        .clk    (clk),
        .rst    (rst),
        .key    (key),
        .start  (start),
        .out    (out),
        .finish (finish)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [SCHED_W-1:0] observed,
                         input logic [SCHED_W-1:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_model[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb_model[w[31:24]], sb_model[w[23:16]], sb_model[w[15:8]], sb_model[w[7:0]]};
    endfunction

    // Classic 44-word FIPS-197 expansion.
    function automatic logic [SCHED_W-1:0] model_schedule(input logic [RK_W-1:0] k);
        logic [31:0]        w [44];
        logic [31:0]        temp;
        logic [7:0]         rc = 8'h01;
        logic [SCHED_W-1:0] s;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc   = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r <= NR; r++)
            s[SCHED_W-1-RK_W*r -: RK_W] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return s;
    endfunction

    function automatic logic [RK_W-1:0] rk_of(input logic [SCHED_W-1:0] s, input int i);
        return s[SCHED_W-1-RK_W*i -: RK_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start an expansion and check finish timing plus the full schedule.
    task automatic expand_and_check(input logic [RK_W-1:0] k, input bit hold, input string name);
        logic [SCHED_W-1:0] exp_s = model_schedule(k);
        key   = k;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        check({name, "_fin_lo"}, finish, 0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check({name, "_fin_lo"}, finish, 0);
        end
        tick();
        check({name, "_fin_hi"}, finish, 1);
        check({name, "_sched"}, out, exp_s);
    endtask

    localparam logic [RK_W-1:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [RK_W-1:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    initial begin
        logic [SCHED_W-1:0] exp_s;
        logic [RK_W-1:0]    rk_key;
        logic [RK_W-1:0]    prev_key;

        rst   = 1'b1;
        start = 1'b0;
        key   = '0;
        build_sbox();
        tick();
        tick();
        check("rst_out", out, 0);
        check("rst_fin", finish, 0);
        rst = 1'b0;

        // Idle with start low: nothing moves.
        key = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_fin", finish, 0);
        end
        check("idle_out", out, 0);

        // FIPS-197 vector with a one-cycle start pulse.
        expand_and_check(FIPS_KEY, 1'b0, "fips");
        check("fips_rk0", rk_of(out, 0), FIPS_KEY);
        check("fips_rk1", rk_of(out, 1), 128'ha0fafe1788542cb123a339392a6c7605);
        check("fips_rk10", rk_of(out, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        exp_s = model_schedule(FIPS_KEY);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_lo_fin", finish, 1);
            check("hold_lo_out", out, exp_s);
        end

        // Same key requested again from DONE: no restart.
        key   = FIPS_KEY;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("same_key_fin", finish, 1);
            check("same_key_out", out, exp_s);
        end

        // New keys from DONE with start held high restart the schedule.
        expand_and_check('0, 1'b1, "zero");
        check("zero_rk1", rk_of(out, 1), 128'h62636363626363636263636362636363);
        check("zero_rk10", rk_of(out, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        expand_and_check(SEQ_KEY, 1'b1, "seq");
        check("seq_rk10", rk_of(out, 10), 128'h13111d7fe3944a17f307a78b4d2b30c5);
        start = 1'b0;
        tick();

        // Reset in the middle of an expansion.
        key   = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out", out, 0);
        check("midrst_fin", finish, 0);
        tick();
        check("midrst_idle_fin", finish, 0);
        expand_and_check({$urandom, $urandom, $urandom, $urandom}, 1'b0, "post_rst");

        // Randomized restarts from DONE.
        prev_key = key;
        for (int n = 0; n < 8; n++) begin
            rk_key = {$urandom, $urandom, $urandom, $urandom};
            if (rk_key == prev_key) rk_key = rk_key ^ 128'h1;
            expand_and_check(rk_key, 1'($urandom_range(0, 1)), "rand");
            prev_key = rk_key;
        end
        start = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
